// File: rtl/switch_ctrl_pkg.sv
// Shared definitions for the multiphase half-bridge switch controller.
//   leg_state_e     : per-leg FSM state codes (4-bit)
//   DEF_*           : default dead time, ack timeout and synchroniser depth
//   cnt_w()         : width of the per-leg dead/timeout counter
package switch_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_OFF   = 4'd0,
    ST_DEAD  = 4'd1,
    ST_P_REQ = 4'd2,
    ST_P_ON  = 4'd3,
    ST_P_REL = 4'd4,
    ST_N_REQ = 4'd5,
    ST_N_ON  = 4'd6,
    ST_N_REL = 4'd7,
    ST_FAULT = 4'd8
  } leg_state_e;

  localparam int DEF_DEAD_CYC    = 3;
  localparam int DEF_TIMEOUT_CYC = 64;
  localparam int DEF_SYNC_STAGES = 2;

  // Counter must hold the larger of the dead-time and timeout limits.
  function automatic int cnt_w(input int dead_cyc, input int timeout_cyc);
    int m;
    m = (dead_cyc > timeout_cyc) ? dead_cyc : timeout_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/phase_leg_fsm.sv
// One half-bridge leg: break-before-make sequencing FSM, dead/timeout
// counter and registered gate commands.
//   clk, rst     : clock, asynchronous active-high reset
//   en, req      : leg enable, target side (1 = P, 0 = N)
//   fault_clr    : one-cycle pulse, releases FAULT to OFF when acks are low
//   sa_p, sa_n   : synchronised switch acknowledgments
//   gp, gn       : gate commands (registered from next state)
//   busy, fault  : leg in a transitional state / leg faulted (registered)
module phase_leg_fsm
  import switch_ctrl_pkg::*;
#(
  parameter int DEAD_CYC    = DEF_DEAD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req,
  input  logic fault_clr,
  input  logic sa_p,
  input  logic sa_n,
  output logic gp,
  output logic gn,
  output logic busy,
  output logic fault
);

  localparam int CNT_W = cnt_w(DEAD_CYC, TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  leg_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             tmo;

  // Waiting states fault once TIMEOUT_CYC clocks have passed since entry.
  assign tmo = (cnt >= TMO_LAST);

  always_comb begin
    state_d = state;
    case (state)
      ST_OFF:   if (en) state_d = ST_DEAD;
      // Dead time runs for counts 0..DEAD_CYC; req is only looked at on expiry,
      // so a req change inside the window never restarts it.
      ST_DEAD:  if (cnt >= DEAD_LAST) begin
                  if (!en)     state_d = ST_OFF;
                  else if (req) state_d = ST_P_REQ;
                  else         state_d = ST_N_REQ;
                end
      ST_P_REQ: if (sa_p) state_d = ST_P_ON;  else if (tmo) state_d = ST_FAULT;
      ST_P_ON:  if (!en || !req) state_d = ST_P_REL;
      ST_P_REL: if (!sa_p) state_d = ST_DEAD; else if (tmo) state_d = ST_FAULT;
      ST_N_REQ: if (sa_n) state_d = ST_N_ON;  else if (tmo) state_d = ST_FAULT;
      ST_N_ON:  if (!en || req) state_d = ST_N_REL;
      ST_N_REL: if (!sa_n) state_d = ST_DEAD; else if (tmo) state_d = ST_FAULT;
      ST_FAULT: if (fault_clr && !sa_p && !sa_n) state_d = ST_OFF;
      default:  state_d = ST_FAULT;
    endcase
    // Opposite switch reporting conduction while this side is driven.
    if ((state == ST_P_REQ || state == ST_P_ON) && sa_n) state_d = ST_FAULT;
    if ((state == ST_N_REQ || state == ST_N_ON) && sa_p) state_d = ST_FAULT;
    // Shoot-through overrides everything, including a fault_clr in FAULT.
    if (sa_p && sa_n) state_d = ST_FAULT;

    if (state_d != state)    cnt_d = '0;
    else if (cnt == CNT_MAX) cnt_d = cnt;
    else                     cnt_d = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OFF;
      cnt   <= '0;
      gp    <= 1'b0;
      gn    <= 1'b0;
      busy  <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      gp    <= (state_d == ST_P_REQ) || (state_d == ST_P_ON);
      gn    <= (state_d == ST_N_REQ) || (state_d == ST_N_ON);
      busy  <= (state_d == ST_DEAD)  || (state_d == ST_P_REQ) || (state_d == ST_P_REL) ||
               (state_d == ST_N_REQ) || (state_d == ST_N_REL);
      fault <= (state_d == ST_FAULT);
    end
  end

endmodule

// File: rtl/multiphase_switch_ctrl.sv
// Gate sequencer for PHASES independent half-bridge legs of a buck stage.
//   clk, rst        : clock, asynchronous active-high reset
//   en, req         : per-leg enable and target side (1 = P, 0 = N)
//   fault_clr       : clears faulted legs back to OFF
//   gp_ack, gn_ack  : asynchronous switch conduction feedback
//   gp, gn          : registered gate commands
//   busy, fault     : per-leg transitional / sticky fault flags
//   fault_any       : registered OR of fault (one clock behind fault)
module multiphase_switch_ctrl
  import switch_ctrl_pkg::*;
#(
  parameter int PHASES      = 4,
  parameter int DEAD_CYC    = DEF_DEAD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PHASES-1:0] en,
  input  logic [PHASES-1:0] req,
  input  logic              fault_clr,
  input  logic [PHASES-1:0] gp_ack,
  input  logic [PHASES-1:0] gn_ack,
  output logic [PHASES-1:0] gp,
  output logic [PHASES-1:0] gn,
  output logic [PHASES-1:0] busy,
  output logic [PHASES-1:0] fault,
  output logic              fault_any
);

  logic [PHASES-1:0] p_sync [SYNC_STAGES];
  logic [PHASES-1:0] n_sync [SYNC_STAGES];
  logic [PHASES-1:0] sa_p, sa_n;

  // Acks come straight from the power stage; only the last stage is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        p_sync[s] <= '0;
        n_sync[s] <= '0;
      end
    end else begin
      p_sync[0] <= gp_ack;
      n_sync[0] <= gn_ack;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        p_sync[s] <= p_sync[s-1];
        n_sync[s] <= n_sync[s-1];
      end
    end
  end

  assign sa_p = p_sync[SYNC_STAGES-1];
  assign sa_n = n_sync[SYNC_STAGES-1];

  for (genvar i = 0; i < PHASES; i++) begin : g_leg
    phase_leg_fsm #(
      .DEAD_CYC    (DEAD_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_leg (
      .clk       (clk),
      .rst       (rst),
      .en        (en[i]),
      .req       (req[i]),
      .fault_clr (fault_clr),
      .sa_p      (sa_p[i]),
      .sa_n      (sa_n[i]),
      .gp        (gp[i]),
      .gn        (gn[i]),
      .busy      (busy[i]),
      .fault     (fault[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_any <= 1'b0;
    else     fault_any <= |fault;
  end

endmodule

// File: tb/tb_multiphase_switch_ctrl.sv
// Self-checking bench for multiphase_switch_ctrl: per-leg behavioural model
// compared every cycle, plus hand-computed timing points.
module tb_multiphase_switch_ctrl;

  localparam int PHASES      = 4;
  localparam int DEAD_CYC    = 3;
  localparam int TIMEOUT_CYC = 64;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] en = '0, req = '0;
  logic       fault_clr = 1'b0;
  logic [3:0] gp_ack = '0, gn_ack = '0;
  logic [3:0] gp, gn, busy, fault;
  logic       fault_any;

  multiphase_switch_ctrl #(
    .PHASES(PHASES), .DEAD_CYC(DEAD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .fault_clr(fault_clr),
    .gp_ack(gp_ack), .gn_ack(gn_ack), .gp(gp), .gn(gn), .busy(busy),
    .fault(fault), .fault_any(fault_any)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- switch model: ack = gate delayed by dly clocks, or forced
  logic [7:0] hp [4] = '{default: '0};
  logic [7:0] hn [4] = '{default: '0};
  int         dly [4] = '{2, 2, 2, 2};
  logic [3:0] fp_en = '0, fp_val = '0, fn_en = '0, fn_val = '0;

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        hp[i] = '0;
        hn[i] = '0;
      end else begin
        hp[i] = {hp[i][6:0], gp[i]};
        hn[i] = {hn[i][6:0], gn[i]};
      end
      gp_ack[i] = fp_en[i] ? fp_val[i] : hp[i][dly[i]-1];
      gn_ack[i] = fn_en[i] ? fn_val[i] : hn[i][dly[i]-1];
    end
  end

  // ---------------- behavioural reference: stage + driven side + countdown
  localparam int S_IDLE = 0, S_GAP = 1, S_ASK = 2, S_HOLD = 3, S_DROP = 4, S_BAD = 5;
  int         m_stage [4];
  int         m_side  [4];
  int         m_left  [4];
  logic [SYNC_STAGES-1:0] m_sp [4];
  logic [SYNC_STAGES-1:0] m_sn [4];
  logic [3:0] m_gp, m_gn, m_busy, m_fault;
  logic       m_fany;

  task automatic enter(input int i, input int st, input int side);
    m_stage[i] = st;
    m_side[i]  = side;
    m_left[i]  = (st == S_GAP) ? DEAD_CYC + 1 : TIMEOUT_CYC;
  endtask

  task automatic leg_step(input int i, input bit sp, input bit sn);
    bit own, opp;
    own = (m_side[i] == 1) ? sp : sn;
    opp = (m_side[i] == 1) ? sn : sp;
    if (sp && sn) enter(i, S_BAD, m_side[i]);
    else if ((m_stage[i] == S_ASK || m_stage[i] == S_HOLD) && opp) enter(i, S_BAD, m_side[i]);
    else begin
      case (m_stage[i])
        S_IDLE: if (en[i]) enter(i, S_GAP, 0);
        S_GAP:  if (m_left[i] == 1) begin
                  if (!en[i]) enter(i, S_IDLE, 0);
                  else        enter(i, S_ASK, req[i] ? 1 : 0);
                end else m_left[i]--;
        S_ASK:  if (own) enter(i, S_HOLD, m_side[i]);
                else if (m_left[i] == 1) enter(i, S_BAD, m_side[i]);
                else m_left[i]--;
        S_HOLD: if (!en[i] || ((req[i] ? 1 : 0) != m_side[i])) enter(i, S_DROP, m_side[i]);
        S_DROP: if (!own) enter(i, S_GAP, 0);
                else if (m_left[i] == 1) enter(i, S_BAD, m_side[i]);
                else m_left[i]--;
        default: if (fault_clr && !sp && !sn) enter(i, S_IDLE, 0);
      endcase
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        enter(i, S_IDLE, 0);
        m_sp[i] = '0;
        m_sn[i] = '0;
      end
      m_fany = 1'b0;
    end else begin
      m_fany = |m_fault;
      for (int i = 0; i < 4; i++) begin
        leg_step(i, m_sp[i][SYNC_STAGES-1], m_sn[i][SYNC_STAGES-1]);
        m_sp[i] = {m_sp[i][SYNC_STAGES-2:0], gp_ack[i]};
        m_sn[i] = {m_sn[i][SYNC_STAGES-2:0], gn_ack[i]};
      end
    end
    for (int i = 0; i < 4; i++) begin
      m_gp[i]    = (m_stage[i] == S_ASK || m_stage[i] == S_HOLD) && m_side[i] == 1;
      m_gn[i]    = (m_stage[i] == S_ASK || m_stage[i] == S_HOLD) && m_side[i] == 0;
      m_busy[i]  = (m_stage[i] == S_GAP || m_stage[i] == S_ASK || m_stage[i] == S_DROP);
      m_fault[i] = (m_stage[i] == S_BAD);
    end
  end

  // ---------------- per-cycle compare + overlap / dead-time scoreboard
  int         cyc = 0;
  int         last_ack [4] = '{-100, -100, -100, -100};
  logic [3:0] gp_q = '0, gn_q = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      gp_q = '0;
      gn_q = '0;
    end else begin
      check("gp", 32'(gp), 32'(m_gp));
      check("gn", 32'(gn), 32'(m_gn));
      check("busy", 32'(busy), 32'(m_busy));
      check("fault", 32'(fault), 32'(m_fault));
      check("fault_any", 32'(fault_any), 32'(m_fany));
      check("overlap", 32'(gp & gn), 0);
      for (int i = 0; i < 4; i++) begin
        if ((gp[i] && !gp_q[i]) || (gn[i] && !gn_q[i])) begin
          vectors++;
          if (cyc - last_ack[i] - 1 < DEAD_CYC) begin
            miscompares++;
            $display("FAIL dead_time leg%0d: got %0d cycles, expected >= %0d", i,
                     cyc - last_ack[i] - 1, DEAD_CYC);
          end
        end
        if (gp_ack[i] || gn_ack[i]) last_ack[i] = cyc;
      end
      gp_q = gp;
      gn_q = gn;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_gp", 32'(gp), 0);
    check("rst_gn", 32'(gn), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_fault_any", 32'(fault_any), 0);
    tick(); tick();

    // 1: leg 0 OFF -> DEAD (1) -> DEAD_CYC+1 clocks -> P_REQ; ack 2 clk, sync 2
    en[0] = 1'b1; req[0] = 1'b1;
    repeat (4) tick();
    check("t1_gp_early", 32'(gp[0]), 0);
    tick();
    check("t1_gp_rise", 32'(gp[0]), 1);
    repeat (3) tick();
    check("t1_busy_wait", 32'(busy[0]), 1);
    tick();
    check("t1_busy_fall", 32'(busy[0]), 0);

    // 2: P_ON -> P_REL, ack falls 2 clk later, 2 sync, DEAD entry, 4 DEAD clocks
    req[0] = 1'b0;
    tick();
    check("t2_gp_off", 32'(gp[0]), 0);
    repeat (7) tick();
    check("t2_gn_early", 32'(gn[0]), 0);
    tick();
    check("t2_gn_rise", 32'(gn[0]), 1);
    repeat (5) tick();

    // 3: leg 1 P ack stuck low -> FAULT TIMEOUT_CYC clocks after P_REQ
    fp_en[1] = 1'b1; fp_val[1] = 1'b0;
    en[1] = 1'b1; req[1] = 1'b1;
    repeat (5) tick();
    check("t3_gp_req", 32'(gp[1]), 1);
    repeat (63) tick();
    check("t3_no_fault_yet", 32'(fault[1]), 0);
    tick();
    check("t3_fault", 32'(fault[1]), 1);
    check("t3_gp_drop", 32'(gp[1]), 0);
    check("t3_leg0_kept", 32'(gn[0]), 1);
    tick();
    check("t3_fault_any", 32'(fault_any), 1);
    en[1] = 1'b0; fp_en[1] = 1'b0;
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("t3_cleared", 32'(fault[1]), 0);

    // 4: leg 2 in N_ON, both acks forced high -> FAULT SYNC_STAGES+1 later
    en[2] = 1'b1; req[2] = 1'b0;
    repeat (5) tick();
    check("t4_gn_req", 32'(gn[2]), 1);
    repeat (4) tick();
    check("t4_n_on", 32'(busy[2]), 0);
    fp_en[2] = 1'b1; fp_val[2] = 1'b1; fn_en[2] = 1'b1; fn_val[2] = 1'b1;
    repeat (2) tick();
    check("t4_not_yet", 32'(fault[2]), 0);
    tick();
    check("t4_fault", 32'(fault[2]), 1);
    check("t4_gn_off", 32'(gn[2]), 0);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("t4_clr_blocked", 32'(fault[2]), 1);
    en[2] = 1'b0; fp_en[2] = 1'b0; fn_en[2] = 1'b0;
    repeat (3) tick();
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("t4_clr_ok", 32'(fault[2]), 0);
    check("t4_off", 32'(busy[2] | gn[2] | gp[2]), 0);

    // 5: async reset with legs 0,1 in P_ON and legs 2,3 in DEAD
    en = '0; req = '0;
    repeat (20) tick();
    check("t5_idle", 32'(busy), 0);
    en = 4'b0011; req = 4'b0011;
    repeat (8) tick();
    en = 4'b1111; req = 4'b1111;
    repeat (2) tick();
    check("t5_pre_gp", 32'(gp), 32'h3);
    check("t5_pre_busy", 32'(busy), 32'hC);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_gp", 32'(gp), 0);
    check("t5_rst_gn", 32'(gn), 0);
    check("t5_rst_busy", 32'(busy), 0);
    en = '0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("t5_after_gp", 32'(gp | gn | busy | fault), 0);
    en[3] = 1'b1; req[3] = 1'b1;
    repeat (4) tick();
    check("t5_restart_early", 32'(gp[3]), 0);
    tick();
    check("t5_restart_rise", 32'(gp[3]), 1);

    // 6: req toggling every 2 clocks with per-leg ack delays 1..5
    en = '0;
    repeat (20) tick();
    for (int i = 0; i < 4; i++) dly[i] = int'($urandom_range(1, 5));
    repeat (10) tick();
    req = 4'b0101; en = 4'b1111;
    for (int k = 0; k < 120; k++) begin
      repeat (2) tick();
      req = ~req;
    end
    check("t6_no_fault", 32'(fault), 0);
    check("t6_no_fault_any", 32'(fault_any), 0);
    en = '0;
    repeat (20) tick();
    check("t6_settled", 32'(gp | gn | busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
